// File: rtl/ccr_branch_unit.sv
// Condition-code register with branch resolution and an interrupt shadow stack.
// Flags are held as {N,C,Z}; branches test a forwarded view so a same-cycle flag write is seen.
module ccr_branch_unit #(
  parameter int FLAG_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [FLAG_W-1:0] alu_flag,
  input  logic              flag_we,
  input  logic [FLAG_W-1:0] flag_mask,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic              int_save,
  input  logic              rti_restore,
  output logic [FLAG_W-1:0] ccr,
  output logic              br_taken,
  output logic              sh_empty,
  output logic              sh_full,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  localparam logic [1:0] BR_JZ  = 2'b00;
  localparam logic [1:0] BR_JN  = 2'b01;
  localparam logic [1:0] BR_JC  = 2'b10;
  localparam logic [1:0] BR_JMP = 2'b11;

  logic [FLAG_W-1:0] ccr_q, ccr_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic [FLAG_W-1:0] stack_q [DEPTH];
  logic [FLAG_W-1:0] stack_d [DEPTH];

  logic [FLAG_W-1:0] fwd;
  logic [FLAG_W-1:0] sel_mask;
  logic              is_jmp;
  logic              taken;
  logic              empty;
  logic              full;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  assign empty    = (sp_q == '0);
  assign full     = (sp_q == SP_FULL);
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = IDX_W'(sp_q - 1'b1);

  // sel_mask marks the flag a conditional branch tests, and later clears if taken.
  always_comb begin
    sel_mask = '0;
    is_jmp   = 1'b0;
    case (br_type)
      BR_JZ:   sel_mask = FLAG_W'(3'b001);
      BR_JN:   sel_mask = FLAG_W'(3'b100);
      BR_JC:   sel_mask = FLAG_W'(3'b010);
      BR_JMP:  is_jmp   = 1'b1;
      default: sel_mask = '0;
    endcase
  end

  always_comb begin
    fwd = ccr_q;
    if (flag_we) begin
      fwd = (alu_flag & flag_mask) | (ccr_q & ~flag_mask);
    end
    taken = br_valid & ~stall & (is_jmp | (|(fwd & sel_mask)));
  end

  always_comb begin
    ccr_d   = ccr_q;
    sp_d    = sp_q;
    err_d   = err_q;
    stack_d = stack_q;
    if (!stall) begin
      if (int_save && rti_restore) begin
        err_d = 1'b1;
      end else if (rti_restore && !empty) begin
        ccr_d = stack_q[pop_idx];
        sp_d  = sp_q - 1'b1;
      end else begin
        if (rti_restore) begin
          err_d = 1'b1;
        end
        ccr_d = fwd & ~(taken ? sel_mask : '0);
        // The shadow copy is the forwarded value, before any branch clear.
        if (int_save) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            stack_d[push_idx] = fwd;
            sp_d              = sp_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      ccr_q <= ccr_d;
      sp_q  <= sp_d;
      err_q <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign ccr      = ccr_q;
  assign br_taken = taken;
  assign sh_empty = empty;
  assign sh_full  = full;
  assign err      = err_q;

endmodule
